// File: rtl/y86_imem_pkg.sv
// Shared constants and FSM state type for the Y86 instruction-memory fetch path.
package y86_imem_pkg;
   localparam int IMEM_DEPTH       = 256;
   localparam int IMEM_INSTR_BYTES = 10;
   localparam int IMEM_ADDR_W      = 8;
   localparam int IMEM_WINDOW_W    = 8 * IMEM_INSTR_BYTES;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      READ = 2'd1,
      LAST = 2'd2,
      DONE = 2'd3
   } fetch_state_t;
endpackage

// File: rtl/imem_rr_arb2.sv
// Two-request round-robin arbiter; the last-grant bit decides ties.
module imem_rr_arb2 (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic req_fetch,
   input  logic req_ld,
   output logic gnt_fetch,
   output logic gnt_ld
);
   // 1 = fetch was served most recently, so the loader wins the next tie
   logic last_fetch_reg;

   assign gnt_ld    = en && req_ld && (!req_fetch || last_fetch_reg);
   assign gnt_fetch = en && req_fetch && !gnt_ld;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)            last_fetch_reg <= 1'b1;
      else if (gnt_ld)    last_fetch_reg <= 1'b0;
      else if (gnt_fetch) last_fetch_reg <= 1'b1;
   end
endmodule

// File: rtl/imem_fetch_arbiter.sv
// Owns the single byte-wide instruction memory port: serves loader writes and
// assembles 10-byte big-endian fetch windows from sequential 1-cycle reads.
module imem_fetch_arbiter
   import y86_imem_pkg::*;
#(
   parameter int MEM_DEPTH   = IMEM_DEPTH,
   parameter int INSTR_BYTES = IMEM_INSTR_BYTES,
   parameter int ADDR_W      = IMEM_ADDR_W
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     fetch_req,
   input  logic [63:0]              fetch_pc,
   output logic [8*INSTR_BYTES-1:0] instr,
   output logic                     instr_valid,
   output logic                     imem_error,
   input  logic                     ld_req,
   input  logic [ADDR_W-1:0]        ld_addr,
   input  logic [7:0]               ld_data,
   output logic                     ld_gnt,
   output logic                     mem_en,
   output logic                     mem_we,
   output logic [ADDR_W-1:0]        mem_addr,
   output logic [7:0]               mem_wdata,
   input  logic [7:0]               mem_rdata,
   output logic                     busy
);
   localparam int          IDX_W     = $clog2(INSTR_BYTES + 1);
   localparam logic [63:0] LAST_ADDR = 64'(MEM_DEPTH - 1);

   fetch_state_t     state_reg;
   logic [IDX_W-1:0] idx_reg;
   logic [63:0]      pc_reg;
   logic             rd_valid_reg;
   logic             instr_valid_reg;
   logic             imem_error_reg;

   logic             arb_en, gnt_fetch, gnt_ld;
   logic             pc_in_range, rd_in_range, oor_load, capture;
   logic [63:0]      byte_addr;
   logic [IDX_W-1:0] cap_idx;

   // Gating with rst keeps every port output quiet while reset is held
   assign arb_en = (state_reg == IDLE) && !rst;

   imem_rr_arb2 u_arb (
      .clk       (clk),
      .rst       (rst),
      .en        (arb_en),
      .req_fetch (fetch_req),
      .req_ld    (ld_req),
      .gnt_fetch (gnt_fetch),
      .gnt_ld    (gnt_ld)
   );

   assign pc_in_range = (fetch_pc <= LAST_ADDR);
   assign byte_addr   = pc_reg + 64'(idx_reg);
   assign rd_in_range = (byte_addr <= LAST_ADDR);
   assign oor_load    = gnt_fetch && !pc_in_range;
   assign capture     = (state_reg == READ) || (state_reg == LAST);
   assign cap_idx     = idx_reg - IDX_W'(1);

   always_comb begin
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = 8'h00;
      if (gnt_ld) begin
         mem_en    = 1'b1;
         mem_we    = 1'b1;
         mem_addr  = ld_addr;
         mem_wdata = ld_data;
      end else if (gnt_fetch && pc_in_range) begin
         mem_en   = 1'b1;
         mem_addr = fetch_pc[ADDR_W-1:0];
      end else if (state_reg == READ && rd_in_range) begin
         mem_en   = 1'b1;
         mem_addr = byte_addr[ADDR_W-1:0];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg       <= IDLE;
         idx_reg         <= '0;
         pc_reg          <= '0;
         rd_valid_reg    <= 1'b0;
         instr_valid_reg <= 1'b0;
         imem_error_reg  <= 1'b0;
      end else begin
         // Remembers whether last cycle's slot came from a real read
         rd_valid_reg <= mem_en && !mem_we;
         case (state_reg)
            IDLE: begin
               instr_valid_reg <= 1'b0;
               if (gnt_fetch) begin
                  pc_reg <= fetch_pc;
                  if (pc_in_range) begin
                     idx_reg        <= IDX_W'(1);
                     imem_error_reg <= 1'b0;
                     state_reg      <= READ;
                  end else begin
                     imem_error_reg  <= 1'b1;
                     instr_valid_reg <= 1'b1;
                     state_reg       <= DONE;
                  end
               end
            end
            READ: begin
               idx_reg <= idx_reg + IDX_W'(1);
               if (idx_reg == IDX_W'(INSTR_BYTES - 1)) state_reg <= LAST;
            end
            LAST: begin
               idx_reg         <= '0;
               instr_valid_reg <= 1'b1;
               state_reg       <= DONE;
            end
            DONE: begin
               instr_valid_reg <= 1'b0;
               state_reg       <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   // Slot gi holds byte PC+gi; slot 0 lands in the top byte of instr
   for (genvar gi = 0; gi < INSTR_BYTES; gi++) begin : g_slot
      logic [7:0] byte_reg;
      always_ff @(posedge clk or posedge rst) begin
         if (rst)
            byte_reg <= 8'h00;
         else if (oor_load)
            byte_reg <= 8'h00;
         else if (capture && cap_idx == IDX_W'(gi))
            byte_reg <= rd_valid_reg ? mem_rdata : 8'h00;
      end
      assign instr[(INSTR_BYTES-gi)*8-1 -: 8] = byte_reg;
   end

   assign ld_gnt      = gnt_ld;
   assign instr_valid = instr_valid_reg;
   assign imem_error  = imem_error_reg;
   assign busy        = (state_reg != IDLE);
endmodule

// File: tb/tb_imem_fetch_arbiter.sv
// Directed bench: fetch vector table plus hand sequences for arbitration and reset.
module tb_imem_fetch_arbiter;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        fetch_req = 1'b0;
   logic [63:0] fetch_pc = '0;
   logic [79:0] instr;
   logic        instr_valid, imem_error;
   logic        ld_req = 1'b0;
   logic [7:0]  ld_addr = '0;
   logic [7:0]  ld_data = '0;
   logic        ld_gnt, mem_en, mem_we;
   logic [7:0]  mem_addr, mem_wdata;
   logic [7:0]  mem_rdata = '0;
   logic        busy;

   int n_checks = 0;
   int n_errors = 0;
   int rd_total = 0;

   logic [7:0] ram [256];

   imem_fetch_arbiter dut (
      .clk(clk), .rst(rst),
      .fetch_req(fetch_req), .fetch_pc(fetch_pc),
      .instr(instr), .instr_valid(instr_valid), .imem_error(imem_error),
      .ld_req(ld_req), .ld_addr(ld_addr), .ld_data(ld_data), .ld_gnt(ld_gnt),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) ram[mem_addr] <= mem_wdata;
         else        mem_rdata <= ram[mem_addr];
      end
   end

   // Counts read cycles issued to the memory port
   always begin
      @(negedge clk);
      #2;
      if (mem_en && !mem_we) rd_total++;
   end

   typedef struct {
      string       name;
      logic [63:0] pc;
      logic [79:0] exp_instr;
      logic        exp_err;
      int          exp_lat;
      int          exp_reads;
   } vec_t;

   vec_t vecs [7];

   task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic wait_valid(output int lat);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!instr_valid && lat < 40);
      if (!instr_valid) lat = -1;
   endtask

   // Called at a negedge; returns at the negedge of the cycle after instr_valid
   task automatic run_fetch(input string name, input logic [63:0] pc, input logic [79:0] exp_instr,
                            input logic exp_err, input int exp_lat, input int exp_reads);
      int lat, r0;
      fetch_pc  = pc;
      fetch_req = 1'b1;
      r0 = rd_total;
      wait_valid(lat);
      fetch_req = 1'b0;
      chk({name, "_lat"}, 80'(lat), 80'(exp_lat));
      chk({name, "_instr"}, instr, exp_instr);
      chk({name, "_err"}, 80'(imem_error), 80'(exp_err));
      chk({name, "_reads"}, 80'(rd_total - r0), 80'(exp_reads));
      $display("fetch %s pc=%0h lat=%0d instr=%h err=%0d reads=%0d",
               name, pc, lat, instr, imem_error, rd_total - r0);
      @(negedge clk);
      chk({name, "_pulse"}, 80'({instr_valid, busy}), 80'(0));
   endtask

   task automatic chk_quiet(input string name);
      chk({name, "_instr"}, instr, 80'h0);
      chk({name, "_outs"}, 80'({instr_valid, imem_error, busy, ld_gnt, mem_en, mem_we}), 80'h0);
      chk({name, "_bus"}, 80'({mem_addr, mem_wdata}), 80'h0);
   endtask

   initial begin
      int lat, gnt_seen, vcount;
      for (int i = 0; i < 256; i++) ram[i] = 8'(i);
      vecs[0] = '{"pc10",  64'h10,  80'h10111213141516171819, 1'b0, 11, 10};
      vecs[1] = '{"pc250", 64'd250, 80'hFAFBFCFDFEFF00000000, 1'b0, 11, 6};
      vecs[2] = '{"pc256", 64'd256, 80'h0,                    1'b1, 1,  0};
      vecs[3] = '{"pc0",   64'h0,   80'h00010203040506070809, 1'b0, 11, 10};
      vecs[4] = '{"pc255", 64'd255, 80'hFF000000000000000000, 1'b0, 11, 1};
      vecs[5] = '{"pcbig", 64'hFFFF_FFFF_FFFF_FFF0, 80'h0,    1'b1, 1,  0};
      vecs[6] = '{"pc246", 64'd246, 80'hF6F7F8F9FAFBFCFDFEFF, 1'b0, 11, 10};

      // Reset state, with requests pending to prove gating
      @(negedge clk);
      ld_req = 1'b1; fetch_req = 1'b1; ld_addr = 8'h33; ld_data = 8'h44;
      #1;
      chk_quiet("reset");
      ld_req = 1'b0; fetch_req = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      for (int v = 0; v < 7; v++)
         run_fetch(vecs[v].name, vecs[v].pc, vecs[v].exp_instr, vecs[v].exp_err,
                   vecs[v].exp_lat, vecs[v].exp_reads);

      // Tie right after reset: loader first, then the fetch sees its write
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      ld_req = 1'b1; ld_addr = 8'h10; ld_data = 8'hAB;
      fetch_req = 1'b1; fetch_pc = 64'h10;
      #1;
      chk("tie_ldgnt", 80'({ld_gnt, mem_en, mem_we}), 80'b111);
      chk("tie_wbus", 80'({mem_addr, mem_wdata}), 80'h10AB);
      $display("tie cycle0 ld_gnt=%0d addr=%h wdata=%h", ld_gnt, mem_addr, mem_wdata);
      @(negedge clk);
      ld_req = 1'b0;
      #1;
      chk("tie_fetch_rd", 80'({ld_gnt, mem_en, mem_we, mem_addr}), 80'({3'b010, 8'h10}));
      wait_valid(lat);
      fetch_req = 1'b0;
      chk("tie_lat", 80'(lat), 80'd11);
      chk("tie_instr", instr, 80'hAB111213141516171819);
      $display("tie fetch lat=%0d instr=%h", lat, instr);
      @(negedge clk);

      // Lone loader write sets last-grant to loader; then fetch wins the tie
      ld_req = 1'b1; ld_addr = 8'h80; ld_data = 8'h80;
      #1;
      chk("lone_ldgnt", 80'(ld_gnt), 80'd1);
      @(negedge clk);
      fetch_req = 1'b1; fetch_pc = 64'h30;
      gnt_seen = 0;
      for (int k = 0; k < 12; k++) begin
         #1;
         if (ld_gnt) gnt_seen++;
         if (k == 11) chk("cont_valid_t11", 80'(instr_valid), 80'd1);
         @(negedge clk);
      end
      fetch_req = 1'b0;
      #1;
      chk("cont_no_gnt", 80'(gnt_seen), 80'd0);
      chk("cont_gnt_t12", 80'(ld_gnt), 80'd1);
      chk("cont_instr", instr, 80'h30313233343536373839);
      $display("cont ld_gnt during fetch=%0d, at T12=%0d, instr=%h", gnt_seen, ld_gnt, instr);
      @(negedge clk);
      ld_req = 1'b0;
      @(negedge clk);

      // Reset at T5 aborts the fetch
      fetch_req = 1'b1; fetch_pc = 64'h20;
      repeat (5) @(negedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk_quiet("midrst");
      fetch_req = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      vcount = 0;
      for (int k = 0; k < 15; k++) begin
         @(negedge clk);
         if (instr_valid) vcount++;
      end
      chk("midrst_no_valid", 80'(vcount), 80'd0);
      $display("midrst valid pulses after abort=%0d", vcount);
      run_fetch("after_rst", 64'h20, 80'h20212223242526272829, 1'b0, 11, 10);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule

// File: doc/imem_fetch_arbiter.md
# imem_fetch_arbiter

Sequencing controller and two-requester arbiter for the Y86 byte-wide instruction memory. It owns the memory's single synchronous read/write port. It serves two requesters: the fetch stage, which needs a 10-byte instruction window per PC, and the program loader, which writes one byte per grant. Each fetch is assembled from ten sequential byte reads into an 80-bit big-endian instruction word, and out-of-range fetches are flagged without any memory access.

## Interface
Parameters:
- MEM_DEPTH, 256, number of bytes in instruction memory
- INSTR_BYTES, 10, bytes per fetch window
- ADDR_W, 8, memory address width (log2 MEM_DEPTH)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- fetch_req  in  1  fetch request; level, held until instr_valid
- fetch_pc  in  64  fetch byte address; stable while fetch_req high
- instr  out  80  assembled instruction; byte at PC in [79:72], PC+9 in [7:0]
- instr_valid  out  1  one-cycle pulse; instr and imem_error valid
- imem_error  out  1  fetch_pc > MEM_DEPTH-1; qualified by instr_valid
- ld_req  in  1  loader write request; held until ld_gnt
- ld_addr  in  ADDR_W  loader byte address
- ld_data  in  8  loader byte
- ld_gnt  out  1  combinational grant; the write happens this cycle
- mem_en  out  1  memory port enable
- mem_we  out  1  write enable (equals ld_gnt)
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  8  write data (ld_data)
- mem_rdata  in  8  read data, one cycle after mem_en with mem_we=0
- busy  out  1  high whenever state != IDLE

## Operation
- States: IDLE, READ, LAST, DONE.
- IDLE arbitration:
  - Round-robin between fetch and loader using a last-grant bit. If only one requests, it wins.
  - Loader win: ld_gnt=1, mem_en=1, mem_we=1, mem_addr=ld_addr; the state stays IDLE.
  - Fetch win, fetch_pc <= MEM_DEPTH-1: latch the PC, issue a read of byte 0 this cycle, set idx=1, and go to READ.
  - Fetch win, fetch_pc > MEM_DEPTH-1: no memory access. Load instr=0 and imem_error=1, then go to DONE.
- READ:
  - Each cycle, capture mem_rdata into the slot for byte idx-1 and issue a read of byte idx, then increment idx.
  - When idx = INSTR_BYTES-1 has been issued, go to LAST.
- LAST: capture byte INSTR_BYTES-1 and go to DONE.
- DONE: assert instr_valid for one cycle, then return to IDLE. The last-grant bit marks fetch as served.
- Address arithmetic:
  - Byte address = latched PC + idx, computed at 64 bits.
  - If the byte address is > MEM_DEPTH-1, the byte is forced to 0x00, mem_en=0 for that slot, and nothing wraps around. imem_error is not raised for this case.
- A fetch is atomic: the loader is never granted in READ, LAST or DONE.
- If fetch_req drops mid-fetch (a protocol violation), the fetch still completes and pulses instr_valid.
- instr holds its value until the next fetch starts loading slots.

## Timing
- Reset (asynchronous): state=IDLE, idx=0, instr=0, instr_valid=0, imem_error=0, busy=0, all mem_* outputs 0, ld_gnt=0. The last-grant bit is set to "fetch", so the loader wins the first tie.
- In-range fetch accepted in cycle T0:
  - Reads are issued in T0..T9 and bytes captured at the ends of T1..T10.
  - instr_valid is high in T11.
  - The earliest next grant is T12.
- Out-of-range fetch accepted in T0: instr_valid and imem_error are high in T1.
- Loader write: takes 1 cycle, granted in the same cycle as the request when selected. A back-to-back fetch request alternates with it.
- A reset asserted mid-fetch aborts the fetch. No instr_valid is produced for the aborted request.

## Structure
- Package y86_imem_pkg: state enum (IDLE/READ/LAST/DONE), INSTR_BYTES, MEM_DEPTH, ADDR_W, and the fetch-window width (8*INSTR_BYTES).
- Sub-module imem_rr_arb2: two-request round-robin arbiter with a last-grant bit, enabled only in IDLE.
- The memory array is external. The bench supplies a synchronous byte RAM with 1-cycle read latency.

## Test plan
- Preload the RAM with 0x00..0xFF at addresses 0..255, then fetch_pc=0x10 -> instr_valid at T11, instr=0x10111213141516171819, imem_error=0.
- fetch_pc=250 -> instr=0xFAFBFCFDFEFF00000000, imem_error=0, and mem_en never asserted for addresses 256..259.
- fetch_pc=256 -> instr_valid at T1, instr=0, imem_error=1, no mem_en.
- ld_req and fetch_req both held in IDLE after reset -> the loader is granted first (write 0xAB at 0x10), the fetch is granted next cycle, and it returns 0xAB in [79:72].
- Continuous ld_req during a fetch -> ld_gnt stays 0 from T0 to T11 and goes to 1 in T12.
- rst asserted at T5 of a fetch -> all outputs are 0 immediately, there is no instr_valid pulse, and the next fetch completes normally.
